// File: rtl/instr_decode_reg.sv
// Instruction decode register: 2-entry skid buffer that decodes MIPS-style fields as words enter.
// Optional build macro IDREG_STALL_CNT_EN adds a saturating output-stall counter.
module instr_decode_reg #(
    parameter int N = 32,
    parameter int M = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [N-1:0] in_instr,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [5:0]   out_opcode,
    output logic [4:0]   out_rs,
    output logic [4:0]   out_rt,
    output logic [4:0]   out_rd,
    output logic [M-1:0] out_imm,
    output logic         out_sx_sel
`ifdef IDREG_STALL_CNT_EN
    ,
    output logic [31:0]  stall_cnt
`endif
);

    typedef struct packed {
        logic [5:0]   opcode;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   rd;
        logic [M-1:0] imm;
        logic         sx_sel;
    } fields_t;

    fields_t in_fields;
    fields_t main_q;
    fields_t skid_q;
    logic    main_valid;
    logic    skid_valid;
    logic    in_ready_q;
    logic    xfer_in;
    logic    xfer_out;

    // Fields are decoded once on entry so the outputs come straight from flops.
    always_comb begin
        in_fields        = '0;
        in_fields.opcode = in_instr[31:26];
        in_fields.rs     = in_instr[25:21];
        in_fields.rt     = in_instr[20:16];
        in_fields.rd     = in_instr[15:11];
        in_fields.imm    = in_instr[M-1:0];
        in_fields.sx_sel = (in_instr[31:28] == 4'b0011);
    end

    assign xfer_in  = in_valid && in_ready_q;
    assign xfer_out = main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (skid_valid) begin
            // in_ready is low here, so only the drain path can fire.
            if (xfer_out) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
                in_ready_q <= 1'b1;
            end
        end else if (!main_valid) begin
            if (xfer_in) begin
                main_q     <= in_fields;
                main_valid <= 1'b1;
            end
        end else begin
            if (xfer_out && xfer_in) begin
                main_q <= in_fields;
            end else if (xfer_out) begin
                main_valid <= 1'b0;
            end else if (xfer_in) begin
                skid_q     <= in_fields;
                skid_valid <= 1'b1;
                in_ready_q <= 1'b0;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = main_valid;
    assign out_opcode = main_q.opcode;
    assign out_rs     = main_q.rs;
    assign out_rt     = main_q.rt;
    assign out_rd     = main_q.rd;
    assign out_imm    = main_q.imm;
    assign out_sx_sel = main_q.sx_sel;

`ifdef IDREG_STALL_CNT_EN
    // Cleared only by rst; flush leaves the history intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_decode_reg.sv
// Self-checking bench for instr_decode_reg: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_instr_decode_reg;

    localparam int N = 32;
    localparam int M = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic [N-1:0] in_instr;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [5:0]   out_opcode;
    logic [4:0]   out_rs;
    logic [4:0]   out_rt;
    logic [4:0]   out_rd;
    logic [M-1:0] out_imm;
    logic         out_sx_sel;
`ifdef IDREG_STALL_CNT_EN
    logic [31:0]  stall_cnt;
    longint       exp_stall;
`endif

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] q[$];

    instr_decode_reg #(.N(N), .M(M)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .out_rd     (out_rd),
        .out_imm    (out_imm),
        .out_sx_sel (out_sx_sel)
`ifdef IDREG_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] w;
        int          op;
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        if (q.size() > 0) begin
            w  = q[0];
            op = int'(w / 32'd67108864);
            chk("opcode", {26'd0, out_opcode}, 32'(op));
            chk("rs", {27'd0, out_rs}, (w >> 21) % 32);
            chk("rt", {27'd0, out_rt}, (w >> 16) % 32);
            chk("rd", {27'd0, out_rd}, (w >> 11) % 32);
            chk("imm", {16'd0, out_imm}, w % 65536);
            chk("sx_sel", {31'd0, out_sx_sel}, {31'd0, (op >= 12 && op <= 15)});
        end
`ifdef IDREG_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'(exp_stall));
`endif
    endtask

    // Model state advances with the inputs that were present at the edge.
    task automatic model_update();
        bit acc;
        bit pop;
        acc = in_valid && (q.size() < 2);
        pop = (q.size() > 0) && out_ready;
`ifdef IDREG_STALL_CNT_EN
        if (rst) exp_stall = 0;
        else if (q.size() > 0 && !out_ready && exp_stall < 64'hFFFF_FFFF) exp_stall++;
`endif
        if (rst || flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(in_instr);
        end
    endtask

    task automatic cycle(input logic f, input logic v, input logic [31:0] w, input logic r);
        rst       = 1'b0;
        flush     = f;
        in_valid  = v;
        in_instr  = w;
        out_ready = r;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("rst_opcode", {26'd0, out_opcode}, 32'd0);
        chk("rst_rs", {27'd0, out_rs}, 32'd0);
        chk("rst_rt", {27'd0, out_rt}, 32'd0);
        chk("rst_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_imm", {16'd0, out_imm}, 32'd0);
        chk("rst_sx", {31'd0, out_sx_sel}, 32'd0);
        check_outputs();
        rst = 1'b0;
    endtask

    localparam logic [31:0] WA = 32'h8C22_0004;
    localparam logic [31:0] WB = 32'hAC43_0008;
    localparam logic [31:0] WC = 32'h3C01_1234;

    initial begin
`ifdef IDREG_STALL_CNT_EN
        exp_stall = 0;
`endif
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // addi, then ori back-to-back
        cycle(0, 1, 32'h2008_FFFF, 1);
        chk("d1_opcode", {26'd0, out_opcode}, 32'h08);
        chk("d1_rt", {27'd0, out_rt}, 32'd8);
        chk("d1_imm", {16'd0, out_imm}, 32'hFFFF);
        chk("d1_sx", {31'd0, out_sx_sel}, 32'd0);
        cycle(0, 1, 32'h3421_ABCD, 1);
        chk("d2_opcode", {26'd0, out_opcode}, 32'h0D);
        chk("d2_rs", {27'd0, out_rs}, 32'd1);
        chk("d2_imm", {16'd0, out_imm}, 32'hABCD);
        chk("d2_sx", {31'd0, out_sx_sel}, 32'd1);
        cycle(0, 0, 0, 1);

        // stall: A in main, B in skid, C offered but refused
        cycle(0, 1, WA, 0);
        cycle(0, 1, WB, 0);
        chk("skid_in_ready", {31'd0, in_ready}, 32'd0);
        cycle(0, 1, WC, 0);
        chk("hold_A", {16'd0, out_imm}, {16'd0, WA[15:0]});
        cycle(0, 0, 0, 1);
        chk("B_after_A", {16'd0, out_imm}, {16'd0, WB[15:0]});
        chk("ready_after_drain", {31'd0, in_ready}, 32'd1);
        cycle(0, 0, 0, 1);
        chk("drained", {31'd0, out_valid}, 32'd0);

        // 100-word stream at full rate
        for (int i = 0; i < 100; i++) begin
            cycle(0, 1, 32'(i), 1);
            chk("stream", {16'd0, out_imm}, 32'(i));
        end
        cycle(0, 0, 0, 1);

        // flush with skid full and a word offered
        cycle(0, 1, WA, 0);
        cycle(0, 1, WB, 0);
        cycle(1, 1, WC, 0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        cycle(0, 0, 0, 1);
        chk("flush_gone", {31'd0, out_valid}, 32'd0);

        // reset mid-stall with skid full
        cycle(0, 1, WA, 0);
        cycle(0, 1, WB, 0);
        do_reset();
        cycle(0, 0, 0, 1);

`ifdef IDREG_STALL_CNT_EN
        cycle(0, 1, WA, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        chk("stall5", stall_cnt, 32'd5);
        cycle(1, 0, 0, 1);
        chk("stall_flush", stall_cnt, 32'd5);
        do_reset();
        chk("stall_rst", stall_cnt, 32'd0);
`endif

        // random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 24) == 0, 1'($urandom_range(0, 3) != 0),
                      $urandom, 1'($urandom_range(0, 2) != 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_decode_reg.md
INSTR_DECODE_REG -- requirements
Module: instr_decode_reg

Interface
REQ-001 SHALL have parameter N, default 32, instruction width in bits.
REQ-002 SHALL have parameter M, default 16, immediate width in bits, fed to the sign-extension stage.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 flush  input  1  discard all held instructions.
REQ-007 in_valid  input  1  fetch offers in_instr.
REQ-008 in_instr  input  N  fetched instruction word.
REQ-009 in_ready  output  1  block accepts in_instr this cycle.
REQ-010 out_valid  output  1  decoded fields valid.
REQ-011 out_ready  input  1  downstream consumes fields this cycle.
REQ-012 out_opcode  output  6  instr[31:26].
REQ-013 out_rs, out_rt, out_rd  output  5 each  instr[25:21], [20:16], [15:11].
REQ-014 out_imm  output  M  instr[M-1:0], raw, unextended.
REQ-015 out_sx_sel  output  1  extension select: 1 for opcodes 0x0C-0x0F (andi, ori, xori, lui), else 0.

Function
REQ-016 SHALL be a 2-entry skid buffer: main register (drives outputs) and skid register.
REQ-017 in_ready SHALL be a registered signal equal to "skid empty"; no combinational path from out_ready to in_ready.
REQ-018 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-019 Main empty, transfer in: word enters main; out_valid=1 next cycle (latency 1).
REQ-020 Main full, transfer out and transfer in same cycle: new word enters main; no skid use.
REQ-021 Main full, no transfer out, transfer in: word enters skid; in_ready=0 next cycle.
REQ-022 Skid full, transfer out: skid moves to main; in_ready=1 next cycle.
REQ-023 Order SHALL be preserved; no word dropped or duplicated outside flush/reset.
REQ-024 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-025 Decoded fields SHALL be computed on entry and registered with the word; outputs driven only from registers.
REQ-026 flush SHALL clear both entries next cycle (out_valid=0, in_ready=1) and ignore any same-cycle transfer in; flush has priority over all transfers.
REQ-027 When out_valid=0, data outputs are don't-care; bench SHALL not check them.

Reset
REQ-028 rst SHALL, at next edge, set out_valid=0, in_ready=1, all data outputs 0, skid empty.
REQ-029 rst SHALL take priority over flush and transfers, including mid-stall with skid full.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-031 Macro IDREG_STALL_CNT_EN SHALL, when defined, add output stall_cnt (32 bits): increments each cycle out_valid && !out_ready, saturates at 0xFFFFFFFF, cleared by rst only (not flush).
REQ-032 Without IDREG_STALL_CNT_EN, port stall_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset then in_instr=0x2008FFFF valid one cycle, out_ready=1 -> next cycle out_valid=1, opcode=0x08, rs=0, rt=8, imm=0xFFFF, sx_sel=0.
REQ-034 in_instr=0x3421ABCD (ori) -> out_opcode=0x0D, rs=1, rt=1, imm=0xABCD, sx_sel=1.
REQ-035 out_ready=0, send words A then B -> B in skid, in_ready=0; outputs hold A; out_ready=1 -> A then B in order, in_ready=1 after B moves to main.
REQ-036 Continuous in_valid and out_ready=1 for 100 words 0..99 -> one word out per cycle, in order, in_ready stays 1.
REQ-037 Skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed words and the offered word never appear.
REQ-038 With IDREG_STALL_CNT_EN: out_ready=0 for 5 cycles with out_valid=1 -> stall_cnt=5; flush -> stall_cnt still 5; rst -> 0.
